mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_load_extract.sv | 36 +++
 rtl/mem_stage.sv | 87 ++++++++
 tb/tb_mem_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, load-size codes and bus layouts for the memory stage
package mem_stage_pkg;

   localparam int ES_MS_BUS_W = 74;
   localparam int MS_WS_BUS_W = 70;

   localparam logic [1:0] LD_B = 2'b00;
   localparam logic [1:0] LD_H = 2'b01;
   localparam logic [1:0] LD_W = 2'b10;

   typedef struct packed {
      logic        ld_unsigned;
      logic [1:0]  ld_size;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_extract.sv
// rtl/mem_stage_load_extract.sv - byte/half/word lane select with sign or zero extension
module mem_stage_load_extract
   import mem_stage_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  off,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw[7:0];
      case (off)
         2'd0:    byte_sel = raw[7:0];
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         default: byte_sel = raw[31:24];
      endcase
      half_sel = off[1] ? raw[31:16] : raw[15:0];
   end

   // Reserved size code 2'b11 falls through to the word path.
   always_comb begin
      data = raw;
      case (ld_size)
         LD_B:    data = {{24{!ld_unsigned && byte_sel[7]}}, byte_sel};
         LD_H:    data = {{16{!ld_unsigned && half_sel[15]}}, half_sel};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: load data capture/extract, writeback handoff, forwarding
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ES_TO_MS_BUS_WD = ES_MS_BUS_W,
   parameter int MS_TO_WS_BUS_WD = MS_WS_BUS_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [4:0]                 ms_to_ds_dest,
   output logic [31:0]                ms_to_ds_result
);

   logic        ms_valid;
   logic        ms_ready_go;
   logic        first;
   logic        buf_valid;
   logic [31:0] rdata_buf;
   es_to_ms_t   ms_bus;
   ms_to_ws_t   ws_bus;
   logic        load_bus;
   logic        leave;
   logic [31:0] raw_data;
   logic [31:0] ld_data;
   logic [31:0] final_result;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign load_bus       = es_to_ms_valid && ms_allowin;
   assign leave          = ms_valid && ws_allowin;

   // The SRAM output only belongs to this instruction in its first cycle,
   // so a stalled load latches it then and reads the latch afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid  <= 1'b0;
         ms_bus    <= '0;
         first     <= 1'b0;
         buf_valid <= 1'b0;
         rdata_buf <= '0;
      end else begin
         if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
         end
         if (load_bus) begin
            ms_bus <= es_to_ms_bus;
         end
         first <= load_bus;
         if (load_bus || leave) begin
            buf_valid <= 1'b0;
         end else if (ms_valid && first) begin
            buf_valid <= 1'b1;
            rdata_buf <= data_sram_rdata;
         end
      end
   end

   assign raw_data = buf_valid ? rdata_buf : data_sram_rdata;

   mem_stage_load_extract u_load_extract (
      .raw         (raw_data),
      .off         (ms_bus.alu_result[1:0]),
      .ld_size     (ms_bus.ld_size),
      .ld_unsigned (ms_bus.ld_unsigned),
      .data        (ld_data)
   );

   assign final_result = ms_bus.res_from_mem ? ld_data : ms_bus.alu_result;

   assign ws_bus.gr_we        = ms_bus.gr_we;
   assign ws_bus.dest         = ms_bus.dest;
   assign ws_bus.final_result = final_result;
   assign ws_bus.pc           = ms_bus.pc;
   assign ms_to_ws_bus        = ws_bus;

   assign ms_to_ds_dest   = ms_bus.dest & {5{ms_valid && ms_bus.gr_we}};
   assign ms_to_ds_result = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [73:0] es_to_ms_bus;
   logic [31:0] data_sram_rdata;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic [4:0]  ms_to_ds_dest;
   logic [31:0] ms_to_ds_result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_to_ds_dest   (ms_to_ds_dest),
      .ms_to_ds_result (ms_to_ds_result)
   );

   function automatic logic [73:0] mk(input logic uns, input logic [1:0] size, input logic rfm,
                                      input logic we, input logic [4:0] dest,
                                      input logic [31:0] alu, input logic [31:0] pc);
      return {uns, size, rfm, we, dest, alu, pc};
   endfunction

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one load, then drive the SRAM word that arrives in its memory cycle.
   task automatic load_check(input string tag, input logic uns, input logic [1:0] size,
                             input logic [1:0] off, input logic [31:0] rdata,
                             input logic [31:0] exp);
      es_to_ms_bus   = mk(uns, size, 1'b1, 1'b1, 5'd7, 32'h1000_0000 | {30'd0, off}, 32'h1C00_0100);
      es_to_ms_valid = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = rdata;
      #1;
      chk(tag, {38'd0, ms_to_ds_result}, {38'd0, exp});
      chk({tag, "_bus"}, {38'd0, ms_to_ws_bus[63:32]}, {38'd0, exp});
   endtask

   initial begin
      reset           = 1'b1;
      ws_allowin      = 1'b1;
      es_to_ms_valid  = 1'b0;
      es_to_ms_bus    = '0;
      data_sram_rdata = 32'hA5A5_A5A5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_allowin", {69'd0, ms_allowin}, 70'd1);
      chk("rst_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
      chk("rst_ds_dest", {65'd0, ms_to_ds_dest}, 70'd0);
      chk("rst_ws_bus", ms_to_ws_bus, 70'd0);
      chk("rst_ds_result", {38'd0, ms_to_ds_result}, 70'd0);
      reset = 1'b0;

      // ALU passthrough
      es_to_ms_bus   = mk(1'b0, 2'b10, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000);
      es_to_ms_valid = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid = 1'b0;
      chk("alu_valid", {69'd0, ms_to_ws_valid}, 70'd1);
      chk("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000});
      chk("alu_ds_dest", {65'd0, ms_to_ds_dest}, 70'd5);

      // byte, half, word and reserved-size loads
      load_check("ldb_off0", 1'b0, 2'b00, 2'd0, 32'h80FF_7F01, 32'h0000_0001);
      load_check("ldb_off1", 1'b0, 2'b00, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
      load_check("ldb_off2", 1'b0, 2'b00, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
      load_check("ldb_off3", 1'b0, 2'b00, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
      load_check("ldbu_off3", 1'b1, 2'b00, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
      load_check("ldh_off2", 1'b0, 2'b01, 2'd2, 32'h8001_7FFE, 32'hFFFF_8001);
      load_check("ldhu_off2", 1'b1, 2'b01, 2'd2, 32'h8001_7FFE, 32'h0000_8001);
      load_check("ldh_off1", 1'b0, 2'b01, 2'd1, 32'h8001_7FFE, 32'h0000_7FFE);
      load_check("ldw", 1'b0, 2'b10, 2'd3, 32'h8001_7FFE, 32'h8001_7FFE);
      load_check("ld_rsvd", 1'b1, 2'b11, 2'd1, 32'h8001_7FFE, 32'h8001_7FFE);
      @(posedge clk); #1;

      // stall hold
      es_to_ms_bus   = mk(1'b0, 2'b10, 1'b1, 1'b1, 5'd8, 32'h2000_0000, 32'h1C00_0200);
      es_to_ms_valid = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      ws_allowin      = 1'b0;
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("stall_c0_result", {38'd0, ms_to_ds_result}, {38'd0, 32'hDEAD_BEEF});
      chk("stall_c0_allowin", {69'd0, ms_allowin}, 70'd0);
      for (int i = 1; i <= 2; i++) begin
         @(posedge clk); #1;
         data_sram_rdata = 32'h0000_0000;
         #1;
         chk($sformatf("stall_c%0d_result", i), {38'd0, ms_to_ds_result}, {38'd0, 32'hDEAD_BEEF});
         chk($sformatf("stall_c%0d_allowin", i), {69'd0, ms_allowin}, 70'd0);
         chk($sformatf("stall_c%0d_valid", i), {69'd0, ms_to_ws_valid}, 70'd1);
      end
      ws_allowin = 1'b1;
      #1;
      chk("stall_rel_result", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'hDEAD_BEEF});
      chk("stall_rel_allowin", {69'd0, ms_allowin}, 70'd1);
      @(posedge clk); #1;
      chk("stall_gone", {69'd0, ms_to_ws_valid}, 70'd0);

      // back-to-back loads then a bubble
      es_to_ms_bus   = mk(1'b0, 2'b10, 1'b1, 1'b1, 5'd3, 32'h3000_0000, 32'h1C00_0300);
      es_to_ms_valid = 1'b1;
      @(posedge clk); #1;
      data_sram_rdata = 32'h1111_1111;
      es_to_ms_bus    = mk(1'b0, 2'b00, 1'b1, 1'b1, 5'd4, 32'h3000_0001, 32'h1C00_0304);
      #1;
      chk("b2b_a_result", {38'd0, ms_to_ds_result}, {38'd0, 32'h1111_1111});
      chk("b2b_a_dest", {65'd0, ms_to_ds_dest}, 70'd3);
      @(posedge clk); #1;
      data_sram_rdata = 32'h0000_8000;
      es_to_ms_valid  = 1'b0;
      #1;
      chk("b2b_b_result", {38'd0, ms_to_ds_result}, {38'd0, 32'hFFFF_FF80});
      chk("b2b_b_dest", {65'd0, ms_to_ds_dest}, 70'd4);
      @(posedge clk); #1;
      chk("bubble_valid", {69'd0, ms_to_ws_valid}, 70'd0);
      chk("bubble_dest", {65'd0, ms_to_ds_dest}, 70'd0);
      chk("bubble_allowin", {69'd0, ms_allowin}, 70'd1);

      // reset while a load is stalled on its buffered data
      es_to_ms_bus   = mk(1'b0, 2'b10, 1'b1, 1'b1, 5'd9, 32'h4000_0000, 32'h1C00_0400);
      es_to_ms_valid = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      ws_allowin      = 1'b0;
      data_sram_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      data_sram_rdata = 32'h0000_0000;
      #1;
      chk("rstst_buffered", {38'd0, ms_to_ds_result}, {38'd0, 32'hCAFE_F00D});
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
      chk("rstst_allowin", {69'd0, ms_allowin}, 70'd1);
      chk("rstst_dest", {65'd0, ms_to_ds_dest}, 70'd0);
      es_to_ms_bus   = mk(1'b0, 2'b10, 1'b1, 1'b1, 5'd10, 32'h5000_0000, 32'h1C00_0500);
      es_to_ms_valid = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'h5A5A_5A5A;
      #1;
      chk("rstst_live", {38'd0, ms_to_ds_result}, {38'd0, 32'h5A5A_5A5A});
      chk("rstst_new_dest", {65'd0, ms_to_ds_dest}, 70'd10);
      ws_allowin = 1'b1;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
